// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: FSM state encoding,
// register file geometry and the default flush length.
package hazard_pkg;

  localparam int NREGS         = 32;
  localparam int REG_AW        = 5;
  localparam int FLUSH_LEN_DEF = 2;
  localparam int CNT_W         = 3;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-writer bitmap: one bit per architectural register, set when a
// writer issues and cleared when that register retires. Register x0 never
// has a pending writer.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  output logic [NREGS-1:0]  pending
);

  localparam logic [NREGS-1:0] X0_MASK = {{(NREGS-1){1'b1}}, 1'b0};

  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  // Decode issue and retire addresses into one-hot masks
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && (set_addr != '0)) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
  end

  // Clear first then set, so a same-cycle retire and re-issue leaves the bit set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= ((pending & ~clr_mask) | set_mask) & X0_MASK;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: scoreboard-based RAW/WAW interlock plus a
// flush FSM that squashes fetch/decode for FLUSH_LEN cycles after a taken jump.
// Optional feature macro HAZ_WB_BYPASS_EN: a source register being written
// back in the same cycle is treated as available (register file write-through).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_LEN = FLUSH_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_rd_wen,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_wen,
  input  logic              jump_en,
  output logic              issue,
  output logic              hold_pc,
  output logic              hold_if_id,
  output logic              bubble_id_ex,
  output logic              flush_if_id,
  output logic [NREGS-1:0]  pending,
  output logic [15:0]       stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_LEN - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             rs1_busy, rs2_busy, rd_busy, hazard;
  logic             stall_inc;

  hazard_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue && id_rd_wen),
    .set_addr (id_rd_addr),
    .clr_en   (wb_wen),
    .clr_addr (wb_rd_addr),
    .pending  (pending)
  );

  // Hazard detection against the registered scoreboard; WAW on rd is never bypassed
  always_comb begin
    rs1_busy = (id_rs1_addr != '0) && pending[id_rs1_addr];
    rs2_busy = (id_rs2_addr != '0) && pending[id_rs2_addr];
    rd_busy  = id_rd_wen && (id_rd_addr != '0) && pending[id_rd_addr];
`ifdef HAZ_WB_BYPASS_EN
    if (wb_wen && (wb_rd_addr == id_rs1_addr)) rs1_busy = 1'b0;
    if (wb_wen && (wb_rd_addr == id_rs2_addr)) rs2_busy = 1'b0;
`else
    // Without write-through a retiring source still stalls until the bit clears
`endif
    hazard = id_valid && (rs1_busy || rs2_busy || rd_busy);
  end

  // FSM state and flush counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state: a jump in either state (re)loads the flush counter
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (jump_en) begin
      state_next = FLUSH;
      cnt_next   = CNT_LOAD;
    end else if (state == FLUSH) begin
      if (cnt == '0) state_next = RUN;
      else           cnt_next   = cnt - 1'b1;
    end
  end

  // Output decode: reset forces idle outputs, jump/flush beats hazard
  always_comb begin
    issue        = 1'b0;
    hold_pc      = 1'b0;
    hold_if_id   = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    stall_inc    = 1'b0;
    if (!rst) begin
      if (jump_en || (state == FLUSH)) begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end else if (hazard) begin
        hold_pc      = 1'b1;
        hold_if_id   = 1'b1;
        bubble_id_ex = 1'b1;
        stall_inc    = 1'b1;
      end else begin
        issue = id_valid;
      end
    end
  end

  // Saturating count of hazard-stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     stall_cnt <= '0;
    else if (stall_inc && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written
// corner sequences, randomized run against a behavioural model, and a long
// stall-counter saturation run.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_rd_wen;
  logic [4:0]  wb_rd_addr;
  logic        wb_wen;
  logic        jump_en;
  logic        issue, hold_pc, hold_if_id, bubble_id_ex, flush_if_id;
  logic [31:0] pending;
  logic [15:0] stall_cnt;

  int num_checks = 0;
  int num_fail   = 0;

`ifdef HAZ_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam int FLEN = 2;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_wen;
    logic [4:0]  wb_addr;
    logic        wb_wen;
    logic        jump;
    logic        exp_issue, exp_hold, exp_bubble, exp_flush;
    logic [31:0] exp_pending;
    logic [15:0] exp_stall;
  } vec_t;

  // Behavioural model state
  bit busy[32];
  int flush_left;
  int stall_m;

  hazard_ctrl #(.FLUSH_LEN(FLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_rd_addr   (id_rd_addr),
    .id_rd_wen    (id_rd_wen),
    .wb_rd_addr   (wb_rd_addr),
    .wb_wen       (wb_wen),
    .jump_en      (jump_en),
    .issue        (issue),
    .hold_pc      (hold_pc),
    .hold_if_id   (hold_if_id),
    .bubble_id_ex (bubble_id_ex),
    .flush_if_id  (flush_if_id),
    .pending      (pending),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] rd, input logic wen, input logic [4:0] wa,
                              input logic ww, input logic j, input logic ei, input logic eh,
                              input logic eb, input logic ef, input logic [31:0] ep,
                              input logic [15:0] es);
    vec_t t;
    t.valid = v; t.rs1 = r1; t.rs2 = r2; t.rd = rd; t.rd_wen = wen;
    t.wb_addr = wa; t.wb_wen = ww; t.jump = j;
    t.exp_issue = ei; t.exp_hold = eh; t.exp_bubble = eb; t.exp_flush = ef;
    t.exp_pending = ep; t.exp_stall = es;
    return t;
  endfunction

  task automatic applyStimulus(input vec_t v);
    id_valid    = v.valid;
    id_rs1_addr = v.rs1;
    id_rs2_addr = v.rs2;
    id_rd_addr  = v.rd;
    id_rd_wen   = v.rd_wen;
    wb_rd_addr  = v.wb_addr;
    wb_wen      = v.wb_wen;
    jump_en     = v.jump;
  endtask

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    checkValue({name, ".issue"},      32'(issue),        32'(v.exp_issue));
    checkValue({name, ".hold_pc"},    32'(hold_pc),      32'(v.exp_hold));
    checkValue({name, ".hold_if_id"}, 32'(hold_if_id),   32'(v.exp_hold));
    checkValue({name, ".bubble"},     32'(bubble_id_ex), 32'(v.exp_bubble));
    checkValue({name, ".flush"},      32'(flush_if_id),  32'(v.exp_flush));
    checkValue({name, ".pending"},    pending,           v.exp_pending);
    checkValue({name, ".stall_cnt"},  32'(stall_cnt),    32'(v.exp_stall));
  endtask

  task automatic resetDut();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    foreach (busy[i]) busy[i] = 1'b0;
    flush_left = 0;
    stall_m    = 0;
  endtask

  // Model expectation for the current inputs, then advance model to the next edge
  task automatic modelStep(output vec_t e);
    bit src1, src2, dst, haz, flushing;
    e = mk(id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rd_wen, wb_rd_addr, wb_wen, jump_en,
           0, 0, 0, 0, 0, 0);
    src1 = (id_rs1_addr != 0) && busy[id_rs1_addr] && !(BYPASS && wb_wen && wb_rd_addr == id_rs1_addr);
    src2 = (id_rs2_addr != 0) && busy[id_rs2_addr] && !(BYPASS && wb_wen && wb_rd_addr == id_rs2_addr);
    dst  = id_rd_wen && (id_rd_addr != 0) && busy[id_rd_addr];
    haz  = id_valid && (src1 || src2 || dst);
    flushing = jump_en || (flush_left > 0);
    for (int i = 0; i < 32; i++) if (busy[i]) e.exp_pending[i] = 1'b1;
    e.exp_stall = 16'(stall_m);
    if (flushing) begin
      e.exp_flush = 1; e.exp_bubble = 1;
    end else if (haz) begin
      e.exp_hold = 1; e.exp_bubble = 1;
      if (stall_m < 65535) stall_m++;
    end else begin
      e.exp_issue = id_valid;
    end
    if (wb_wen) busy[wb_rd_addr] = 1'b0;
    if (e.exp_issue && id_rd_wen && id_rd_addr != 0) busy[id_rd_addr] = 1'b1;
    if (jump_en) flush_left = FLEN;
    else if (flush_left > 0) flush_left--;
  endtask

  vec_t tbl[20];
  vec_t e;

  initial begin
    rst = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    checkValue("reset.pending", pending, 32'h0);
    checkValue("reset.stall", 32'(stall_cnt), 32'h0);
    checkValue("reset.issue", 32'(issue), 32'h0);
    resetDut();

    //            v rs1 rs2 rd wen wb ww j | is ho bu fl pending stall
    tbl[0]  = mk(1, 1, 2, 5, 1, 0, 0, 0,   1, 0, 0, 0, 32'h00, 0);
    tbl[1]  = mk(1, 5, 0, 6, 1, 0, 0, 0,   0, 1, 1, 0, 32'h20, 0);
    tbl[2]  = mk(1, 3, 4, 5, 1, 0, 0, 0,   0, 1, 1, 0, 32'h20, 1);
    tbl[3]  = mk(0, 5, 0, 0, 0, 5, 1, 0,   0, 0, 0, 0, 32'h20, 2);
    tbl[4]  = mk(1, 5, 5, 7, 1, 0, 0, 0,   1, 0, 0, 0, 32'h00, 2);
    tbl[5]  = mk(1, 7, 0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 32'h80, 2);
    tbl[6]  = mk(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 32'h80, 2);
    tbl[7]  = mk(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 32'h80, 2);
    tbl[8]  = mk(1, 1, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 32'h80, 2);
    tbl[9]  = mk(1, 0, 0, 7, 1, 7, 1, 0,   0, 1, 1, 0, 32'h80, 2);
    tbl[10] = mk(1, 0, 0, 7, 1, 0, 0, 0,   1, 0, 0, 0, 32'h00, 3);
    tbl[11] = mk(0, 0, 0, 0, 0, 7, 1, 0,   0, 0, 0, 0, 32'h80, 3);
    tbl[12] = mk(1, 0, 0, 7, 1, 7, 1, 0,   1, 0, 0, 0, 32'h00, 3);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 32'h80, 3);
    tbl[14] = mk(1, 7, 0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 32'h80, 3);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 32'h80, 3);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 32'h80, 3);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 32'h80, 3);
    tbl[18] = mk(1, 7, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 32'h80, 3);
    tbl[19] = mk(1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 32'h80, 4);

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset during FLUSH with x5 and x7 pending
    @(posedge clk); #1;
    applyStimulus(mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkValue("midflush.flush", 32'(flush_if_id), 32'h1);
    checkValue("midflush.pending", pending, 32'hA0);
    rst = 1'b1;
    jump_en = 1'b1;
    #1;
    checkOutput("async_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0));
    jump_en = 1'b0;
    #1 rst = 1'b0;
    #1;
    checkValue("post_rst.issue", 32'(issue), 32'h1);
    checkValue("post_rst.flush", 32'(flush_if_id), 32'h0);

    // RAW stall on x5 released by write-back
    resetDut();
    @(posedge clk); #1;
    applyStimulus(mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkValue("raw.issue_wr", 32'(issue), 32'h1);
    @(posedge clk); #1;
    applyStimulus(mk(1, 5, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkOutput("raw.stall", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h20, 16'h0));
    @(posedge clk); #1;
    applyStimulus(mk(1, 5, 0, 6, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkValue("raw.wb_stall_cnt", 32'(stall_cnt), 32'h1);
`ifdef HAZ_WB_BYPASS_EN
    checkValue("raw.wb_issue", 32'(issue), 32'h1);
    checkValue("raw.wb_hold", 32'(hold_pc), 32'h0);
    @(posedge clk); #1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkValue("raw.after_pending", pending, 32'h40);
    checkValue("raw.after_stall", 32'(stall_cnt), 32'h1);
`else
    checkValue("raw.wb_issue", 32'(issue), 32'h0);
    checkValue("raw.wb_hold", 32'(hold_pc), 32'h1);
    @(posedge clk); #1;
    applyStimulus(mk(1, 5, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkValue("raw.after_issue", 32'(issue), 32'h1);
    checkValue("raw.after_pending", pending, 32'h0);
    checkValue("raw.after_stall", 32'(stall_cnt), 32'h2);
`endif

    // Randomized run against the behavioural model
    resetDut();
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      applyStimulus(mk(($urandom % 4) != 0, 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8),
                       1'($urandom % 2), 5'($urandom % 8), ($urandom % 3) == 0, ($urandom % 20) == 0,
                       0, 0, 0, 0, 0, 0));
      @(negedge clk);
      modelStep(e);
      checkOutput($sformatf("rand%0d", n), e);
    end

    // Continuous hazard: stall counter saturates
    resetDut();
    @(posedge clk); #1;
    applyStimulus(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (65534) @(posedge clk);
    @(negedge clk);
    checkValue("sat.fffe", 32'(stall_cnt), 32'hFFFE);
    @(posedge clk);
    @(negedge clk);
    checkValue("sat.ffff", 32'(stall_cnt), 32'hFFFF);
    repeat (4465) @(posedge clk);
    @(negedge clk);
    checkValue("sat.hold", 32'(stall_cnt), 32'hFFFF);
    checkValue("sat.hold_pc", 32'(hold_pc), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
